clk_div_prog_50dut: RTL
=======================

CLK_DIV_PROG_50DUT -- requirements
Module: clk_div_prog_50dut

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the divisor; legal 2..16.
REQ-002 Parameter DEFAULT_DIV, default 9: divisor loaded by reset; SHALL be in 2..2^WIDTH-1.
REQ-003 clk  input  1  reference clock; posedge logic plus one negedge flop.
REQ-004 reset  input  1  synchronous, active-low; sampled on posedge clk.
REQ-005 en  input  1  divider run enable; sampled only at period boundary.
REQ-006 load  input  1  one-cycle request to latch div_in.
REQ-007 div_in  input  WIDTH  requested divisor N.
REQ-008 clk_out  output  1  divided clock.
REQ-009 tick  output  1  one-clk pulse, high in the first clk cycle of each clk_out period.
REQ-010 ready  output  1  high when no divisor update is pending.
REQ-011 load_err  output  1  one-cycle pulse when a rejected divisor is loaded.
REQ-012 div_cur  output  WIDTH  divisor currently in force.
REQ-013 VDD, VSS  inout  1  supply pins; no logic function.

Function
REQ-014 Counter cnt SHALL run 0..N-1 and wrap to 0; cycle with cnt==N-1 is the period boundary.
REQ-015 Registered phase hi SHALL be 1 while cnt < floor(N/2), else 0.
REQ-016 Even N: clk_out = hi; high exactly N/2 clk cycles, low N/2.
REQ-017 Odd N: negedge flop ext <= hi; clk_out = hi | ext; high (N-1)/2 + 0.5 cycles, low the same; glitch-free, since ext overlaps hi.
REQ-018 Even N: ext SHALL be forced 0.
REQ-019 tick SHALL be 1 when cnt==0 and the divider is running.
REQ-020 load with div_in >= 2: latch into pending register, ready drops the next cycle.
REQ-021 Pending divisor SHALL take effect at the next period boundary: cnt restarts at 0 under the new N, div_cur updates, ready rises.
REQ-022 A second load while pending SHALL overwrite the pending value; last one wins.
REQ-023 load with div_in 0 or 1: ignore it, pulse load_err one cycle, leave pending and ready unchanged.
REQ-024 Load at the boundary cycle itself SHALL apply at the following boundary, not the current one.
REQ-025 en SHALL be sampled at the boundary only. en=0 there: cnt holds 0, hi=0, ext=0, tick=0 until en=1.
REQ-026 While stopped, en=1 SHALL restart with cnt=0 on the next cycle, after any pending update is applied.
REQ-027 Divisor updates while stopped SHALL apply immediately on the cycle after load.
REQ-028 No clk_out high pulse SHALL be shorter than floor(min(Nold,Nnew)/2) clk cycles.

Reset
REQ-029 reset=0 at posedge SHALL set cnt=0, hi=0, tick=0, load_err=0, ready=1, div_cur=DEFAULT_DIV, and clear pending.
REQ-030 reset=0 at negedge SHALL clear ext; clk_out=0 throughout reset.
REQ-031 Reset asserted mid-period SHALL abort the period and discard any pending load.
REQ-032 After release, the divider SHALL start with en sampled on the first posedge: tick, with clk_out high when N>=2.

Configuration
REQ-033 Macro CLK_DIV_ODD_DUTY_EN. Defined: odd N gets the 50% duty of REQ-017. Undefined: ext flop absent, clk_out = hi for all N (odd N high (N-1)/2, low (N+1)/2), no negedge logic.

Verification
REQ-034 Reset, en=1, DEFAULT_DIV=9, macro on -> clk_out period 9 clk, high 4.5 cycles, tick every 9 cycles.
REQ-035 load div_in=4 mid-period -> ready=0 until boundary, then period 4, high 2, div_cur=4.
REQ-036 load 6 then load 12 before the boundary -> only 12 applied; no period of 6 observed.
REQ-037 load div_in=1 -> load_err one cycle, ready stays 1, div_cur unchanged.
REQ-038 en=0 mid-period -> current period completes, then clk_out=0, tick=0; en=1 -> tick next cycle.
REQ-039 Macro off, N=5 -> high 2 cycles, low 3; reset=0 mid-period -> clk_out=0, div_cur=9.

Source files
------------

// File: rtl/clk_div_prog_50dut.sv
// ---------------------------------------------------------------------------
// clk_div_prog_50dut
//
// Programmable clock divider. Divides clk by a runtime-loadable divisor N
// (2..2^WIDTH-1). A new divisor is held pending and only takes effect at a
// period boundary, so clk_out never produces a runt pulse.
//
// Optional feature macro: CLK_DIV_ODD_DUTY_EN
//   defined   -> odd N gets 50% duty via a negedge extension flop
//   undefined -> clk_out = hi for every N, no negedge logic at all
//
// Ports:
//   clk       reference clock
//   reset     synchronous, active-low reset (sampled on posedge clk)
//   en        run enable, sampled only at a period boundary
//   load      one-cycle request to latch div_in
//   div_in    requested divisor
//   clk_out   divided clock
//   tick      high during the first clk cycle of every clk_out period
//   ready     high when no divisor update is pending
//   load_err  one-cycle pulse when a divisor of 0 or 1 was rejected
//   div_cur   divisor currently in force
//   VDD, VSS  supply pins, no logic function
// ---------------------------------------------------------------------------
module clk_div_prog_50dut #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             ready,
  output logic             load_err,
  output logic [WIDTH-1:0] div_cur,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             hi, hi_n;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] pend_val, pend_n;
  logic             pend_valid, pend_valid_n;
  logic             load_err_n;
  logic             boundary;
  logic             load_ok;

  // Supply pins carry no logic; fold them into a sink so they are visibly used.
  wire unused_supply = VDD ^ VSS;

  // Next-state logic. While stopped every cycle behaves like a period
  // boundary, so pending divisors and a rising en are picked up at once.
  // A load that arrives on the boundary edge itself is captured after the
  // old pending value has been applied, so it waits for the next boundary.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hi_n         = hi;
    div_n        = div_cur;
    pend_n       = pend_val;
    pend_valid_n = pend_valid;
    load_ok      = load && (div_in >= WIDTH'(2));
    load_err_n   = load && !load_ok;
    boundary     = (state == ST_STOP) || (cnt == div_cur - WIDTH'(1));

    if (boundary) begin
      if (pend_valid) begin
        div_n = pend_val;
      end
      pend_valid_n = 1'b0;
      cnt_n        = '0;
      if (en) begin
        // floor(N/2) >= 1 for any legal N, so cnt=0 is always in the high phase
        state_n = ST_RUN;
        hi_n    = 1'b1;
      end else begin
        state_n = ST_STOP;
        hi_n    = 1'b0;
      end
    end else begin
      cnt_n = cnt + WIDTH'(1);
      hi_n  = (cnt_n < (div_cur >> 1));
    end

    if (load_ok) begin
      pend_n       = div_in;
      pend_valid_n = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_STOP;
      cnt        <= '0;
      hi         <= 1'b0;
      div_cur    <= WIDTH'(DEFAULT_DIV);
      pend_val   <= '0;
      pend_valid <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hi         <= hi_n;
      div_cur    <= div_n;
      pend_val   <= pend_n;
      pend_valid <= pend_valid_n;
      load_err   <= load_err_n;
    end
  end

  assign tick  = (state == ST_RUN) && (cnt == '0);
  assign ready = !pend_valid;

`ifdef CLK_DIV_ODD_DUTY_EN
  logic ext;

  // Half-cycle extension for odd N: ext follows hi half a cycle late, so
  // hi | ext stretches the high phase by 0.5 clk without a gap between them.
  // Forced low for even N where hi alone already gives 50% duty.
  always_ff @(negedge clk) begin
    if (!reset) begin
      ext <= 1'b0;
    end else begin
      ext <= hi & div_cur[0];
    end
  end

  assign clk_out = hi | ext;
`else
  assign clk_out = hi;
`endif

endmodule
